// File: rtl/dac_playback_ctrl.sv
// Purpose: playback controller between a waveform FIFO and one DAC AXI-Stream input.
//          It adds a start delay, multi-pass repeat, head/tail beat masks, abort and status flags.
// Latency: one cycle from beat accept to m_axis_tdata; the first beat is accepted delay+1 cycles after the trigger edge.
// Backpressure: none towards the DAC, which always takes data. In RUN, s_axis_tready is 1 every cycle and one beat is consumed per cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   cfg_*       : configuration; latched into shadow registers on cfg_we in IDLE only
//   trigger_in  : start request (level); abort_in: stop; status_clr: clear sticky flags
//   s_axis_*    : waveform FIFO side; m_axis_*: DAC side; loopback_valid: write-back strobe
//   busy, done, aborted, underflow, trig_overrun : status
module dac_playback_ctrl #(
    parameter int DATA_W = 256,
    parameter int LEN_W  = 32,
    parameter int REP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [LEN_W-1:0]  cfg_delay,
    input  logic [REP_W-1:0]  cfg_repeat,
    input  logic [DATA_W-1:0] cfg_head_mask,
    input  logic [DATA_W-1:0] cfg_tail_mask,
    input  logic              cfg_loopback,
    input  logic              trigger_in,
    input  logic              abort_in,
    input  logic              status_clr,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              loopback_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              underflow,
    output logic              trig_overrun
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]  len_sh, delay_sh;
    logic [REP_W-1:0]  rep_sh;
    logic [DATA_W-1:0] head_sh, tail_sh;
    logic              lb_sh;

    logic [LEN_W-1:0]  beat_cnt, dly_cnt;
    logic [REP_W-1:0]  rep_cnt;

    logic              start, abort_evt, accept, first, last;
    logic [DATA_W-1:0] beat_dat;

    // The DAC never stalls, so its tready carries no information.
    logic unused_tready;
    assign unused_tready = m_axis_tready;

    assign m_axis_tvalid = 1'b1;

    // The trigger compares against the shadow values that are already stored.
    // A cfg_we in the same cycle therefore only affects the next run.
    assign start     = (state == IDLE) && trigger_in && (len_sh != '0);
    assign abort_evt = abort_in && ((state == DELAY) || (state == RUN));
    // A beat is consumed in every RUN cycle except the cycle in which abort is asserted.
    assign accept    = (state == RUN) && !abort_in;
    assign first     = (beat_cnt == len_sh);
    assign last      = (beat_cnt == LEN_W'(1));

    always_comb begin
        beat_dat = s_axis_tvalid ? s_axis_tdata : '0;
        if (first) beat_dat = beat_dat & head_sh;
        if (last)  beat_dat = beat_dat & tail_sh;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (delay_sh != '0) ? DELAY : RUN;
            DELAY: begin
                if (abort_in)                    state_nxt = DONE;
                else if (dly_cnt == LEN_W'(1))   state_nxt = RUN;
            end
            RUN: begin
                if (abort_in)                    state_nxt = DONE;
                else if (last && rep_cnt == '0)  state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s_axis_tready  = accept;
        busy           = (state != IDLE);
        done           = (state == DONE);
        loopback_valid = accept && s_axis_tvalid && lb_sh;
    end

    // Shadow registers, counters and output data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_sh       <= '0;
            delay_sh     <= '0;
            rep_sh       <= '0;
            head_sh      <= '0;
            tail_sh      <= '0;
            lb_sh        <= 1'b0;
            beat_cnt     <= '0;
            dly_cnt      <= '0;
            rep_cnt      <= '0;
            m_axis_tdata <= '0;
        end else begin
            if (state == IDLE && cfg_we) begin
                len_sh   <= cfg_len;
                delay_sh <= cfg_delay;
                rep_sh   <= cfg_repeat;
                head_sh  <= cfg_head_mask;
                tail_sh  <= cfg_tail_mask;
                lb_sh    <= cfg_loopback;
            end
            if (start) begin
                beat_cnt <= len_sh;
                rep_cnt  <= rep_sh;
                dly_cnt  <= delay_sh;
            end
            if (state == DELAY) dly_cnt <= dly_cnt - LEN_W'(1);
            if (accept) begin
                // At the end of a pass, start the next one with no gap beat.
                if (last && rep_cnt != '0) begin
                    rep_cnt  <= rep_cnt - REP_W'(1);
                    beat_cnt <= len_sh;
                end else begin
                    beat_cnt <= beat_cnt - LEN_W'(1);
                end
            end
            m_axis_tdata <= accept ? beat_dat : '0;
        end
    end

    // Sticky flags. A set event in the same cycle as status_clr wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aborted      <= 1'b0;
            underflow    <= 1'b0;
            trig_overrun <= 1'b0;
        end else begin
            underflow    <= (accept && !s_axis_tvalid) || (underflow && !status_clr);
            trig_overrun <= (trigger_in && state != IDLE) || (trig_overrun && !status_clr);
            aborted      <= abort_evt || (aborted && !status_clr && !start);
        end
    end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Purpose: directed bench for dac_playback_ctrl. It runs a table of playback scenarios and then hand-written abort, overrun and len=0 sequences.
// Latency: inputs are driven 1 ns after each rising edge, and outputs are sampled 1 ns later.
// Backpressure: m_axis_tready is held at 1.
module tb_dac_playback_ctrl;

    localparam int DW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [31:0]     cfg_len, cfg_delay;
    logic [15:0]     cfg_repeat;
    logic [DW-1:0]   cfg_head_mask, cfg_tail_mask;
    logic            cfg_loopback, trigger_in, abort_in, status_clr;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid, s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready;
    logic            loopback_valid, busy, done, aborted, underflow, trig_overrun;

    always #5 clk = ~clk;

    dac_playback_ctrl dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_delay(cfg_delay),
        .cfg_repeat(cfg_repeat), .cfg_head_mask(cfg_head_mask), .cfg_tail_mask(cfg_tail_mask),
        .cfg_loopback(cfg_loopback), .trigger_in(trigger_in), .abort_in(abort_in),
        .status_clr(status_clr), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .loopback_valid(loopback_valid), .busy(busy), .done(done),
        .aborted(aborted), .underflow(underflow), .trig_overrun(trig_overrun)
    );

    typedef struct {
        int            len;
        int            dly;
        int            rep;
        logic [DW-1:0] head;
        logic [DW-1:0] tail;
        bit            ones;
        bit            lb;
        int            uf_beat;    // beat index driven with tvalid=0, -1 for none
        int            exp_first;  // offset of first tready after trigger sample
        int            exp_beats;  // total accepted beats
        bit            exp_uf;
    } vec_t;

    vec_t vecs[5];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Wait for the rising edge, then move 1 ns past it before driving inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int j);
        logic [31:0] w;
        w = 32'h5A000000 + 32'(j) * 32'h00010203;
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] exp_beat(input vec_t v, input int j);
        logic [DW-1:0] d;
        d = v.ones ? {DW{1'b1}} : pat(j);
        if (j == v.uf_beat)       d = '0;
        if (j % v.len == 0)       d = d & v.head;
        if (j % v.len == v.len-1) d = d & v.tail;
        return d;
    endfunction

    task automatic idle_inputs();
        cfg_we = 0; trigger_in = 0; abort_in = 0; status_clr = 0;
        s_axis_tvalid = 1; s_axis_tdata = pat(0);
    endtask

    task automatic do_cfg(input int len, input int dly, input int rep,
                          input logic [DW-1:0] head, input logic [DW-1:0] tail, input bit lb);
        cyc();
        idle_inputs();
        cfg_we = 1; cfg_len = 32'(len); cfg_delay = 32'(dly); cfg_repeat = 16'(rep);
        cfg_head_mask = head; cfg_tail_mask = tail; cfg_loopback = lb;
        cyc();
        cfg_we = 0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [DW-1:0] exp_prev;
        int            acc;
        bit            in_run;
        string         nm;
        do_cfg(v.len, v.dly, v.rep, v.head, v.tail, v.lb);
        cyc();
        idle_inputs();
        trigger_in = 1;
        exp_prev = '0;
        acc = 0;
        for (int k = 1; k <= v.exp_first + v.exp_beats + 1; k++) begin
            cyc();
            trigger_in    = 0;
            s_axis_tvalid = (acc == v.uf_beat) ? 1'b0 : 1'b1;
            s_axis_tdata  = v.ones ? {DW{1'b1}} : pat(acc);
            #1;
            in_run = (k >= v.exp_first) && (k < v.exp_first + v.exp_beats);
            nm = $sformatf("v%0d_k%0d", id, k);
            chk({nm, "_tready"}, DW'(s_axis_tready), DW'(in_run));
            chk({nm, "_loopback"}, DW'(loopback_valid), DW'(in_run && s_axis_tvalid && v.lb));
            chk({nm, "_tdata"}, m_axis_tdata, exp_prev);
            chk({nm, "_done"}, DW'(done), DW'(k == v.exp_first + v.exp_beats));
            chk({nm, "_busy"}, DW'(busy), DW'(k <= v.exp_first + v.exp_beats));
            if (in_run) begin
                exp_prev = exp_beat(v, acc);
                acc++;
            end else begin
                exp_prev = '0;
            end
        end
        chk($sformatf("v%0d_underflow", id), DW'(underflow), DW'(v.exp_uf));
        chk($sformatf("v%0d_overrun", id), DW'(trig_overrun), DW'(0));
        chk($sformatf("v%0d_aborted", id), DW'(aborted), DW'(0));
        cyc();
        status_clr = 1;
        cyc();
        status_clr = 0;
        #1;
        chk($sformatf("v%0d_underflow_clr", id), DW'(underflow), DW'(0));
    endtask

    int  beats;
    bit  seen_done;

    initial begin
        vecs[0] = '{4, 0, 0, 256'hFF, {8'hFF, 248'h0}, 0, 0, -1, 1, 4, 0};
        vecs[1] = '{3, 5, 2, 256'hFF, {8'hFF, 248'h0}, 0, 0, -1, 6, 9, 0};
        vecs[2] = '{1, 0, 0, {16{16'h0FFF}}, {16{16'hFFF0}}, 1, 0, -1, 1, 1, 0};
        vecs[3] = '{4, 0, 0, {DW{1'b1}}, {DW{1'b1}}, 0, 0, 1, 1, 4, 1};
        vecs[4] = '{2, 1, 1, 256'h0F, {DW{1'b1}}, 0, 1, -1, 2, 4, 0};

        rst = 0; m_axis_tready = 1;
        cfg_len = 0; cfg_delay = 0; cfg_repeat = 0; cfg_head_mask = 0; cfg_tail_mask = 0;
        cfg_loopback = 0;
        idle_inputs();
        trigger_in = 1; // must be ignored while in reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_tvalid", DW'(m_axis_tvalid), DW'(1));
        chk("rst_flags", DW'({aborted, underflow, trig_overrun}), DW'(0));
        chk("rst_tready", DW'(s_axis_tready), DW'(0));
        trigger_in = 0;
        rst = 1;
        // Shadow len is 0 after reset, so a trigger must not start a run.
        cyc();
        trigger_in = 1;
        cyc();
        trigger_in = 0;
        #1;
        chk("rst_len0_busy", DW'(busy), DW'(0));

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Abort during the 3rd beat of len=10, then retrigger.
        do_cfg(10, 0, 0, {DW{1'b1}}, {DW{1'b1}}, 0);
        cyc(); idle_inputs(); trigger_in = 1;
        cyc(); trigger_in = 0;          // beat 1
        cyc();                          // beat 2
        cyc(); abort_in = 1; #1;        // 3rd beat cycle
        chk("abort_tready", DW'(s_axis_tready), DW'(0));
        cyc(); abort_in = 0; #1;
        chk("abort_tdata0", m_axis_tdata, '0);
        chk("abort_done", DW'(done), DW'(1));
        chk("abort_flag", DW'(aborted), DW'(1));
        chk("abort_no_underflow", DW'(underflow), DW'(0));
        cyc(); #1;
        chk("abort_idle", DW'(busy), DW'(0));
        trigger_in = 1;
        cyc(); trigger_in = 0; #1;
        chk("retrig_tready", DW'(s_axis_tready), DW'(1));
        chk("retrig_aborted_clr", DW'(aborted), DW'(0));
        seen_done = 0;
        for (int i = 0; i < 30 && !seen_done; i++) begin
            cyc(); #1;
            if (done) seen_done = 1;
        end
        chk("retrig_done_seen", DW'(seen_done), DW'(1));

        // Trigger and cfg_we while busy: trigger sets overrun, cfg_we is ignored.
        do_cfg(8, 0, 0, {DW{1'b1}}, {DW{1'b1}}, 0);
        cyc(); idle_inputs(); trigger_in = 1;
        beats = 0; seen_done = 0;
        for (int k = 1; k <= 30 && !seen_done; k++) begin
            cyc();
            trigger_in = (k == 2);
            cfg_we = (k == 2); cfg_len = 2;
            #1;
            if (k == 3) chk("overrun_set", DW'(trig_overrun), DW'(1));
            if (s_axis_tready) beats++;
            if (done) seen_done = 1;
        end
        chk("overrun_beats", DW'(beats), DW'(8));
        cyc(); #1;
        trigger_in = 1;
        beats = 0; seen_done = 0;
        for (int k = 1; k <= 30 && !seen_done; k++) begin
            cyc(); trigger_in = 0; #1;
            if (s_axis_tready) beats++;
            if (done) seen_done = 1;
        end
        chk("cfg_ignored_beats", DW'(beats), DW'(8));
        cyc(); status_clr = 1;
        cyc(); status_clr = 0; #1;
        chk("overrun_clr", DW'(trig_overrun), DW'(0));

        // A trigger with len=0 leaves the controller idle.
        do_cfg(0, 3, 0, {DW{1'b1}}, {DW{1'b1}}, 0);
        cyc(); idle_inputs(); trigger_in = 1;
        for (int k = 1; k <= 3; k++) begin
            cyc(); trigger_in = 0; #1;
            chk($sformatf("len0_busy_k%0d", k), DW'(busy), DW'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
